// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one external combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_W  = 32,
  parameter int CTRL_W  = 4,
  parameter int TAG_W   = 4,
  parameter bit RR_INIT = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic [CTRL_W-1:0] req0_ctrl,
  input  logic [TAG_W-1:0]  req0_tag,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  input  logic [CTRL_W-1:0] req1_ctrl,
  input  logic [TAG_W-1:0]  req1_tag,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_control,
  input  logic [DATA_W-1:0] alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              rsp_src,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t              state_q, state_d;
  logic                rr_q, rr_d, src_q, src_d, rsp_src_q, rsp_src_d;
  logic                rsp_valid_q, rsp_valid_d, busy_q, busy_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d, rsp_data_q, rsp_data_d;
  logic [CTRL_W-1:0]   alu_ctrl_q, alu_ctrl_d;
  logic [TAG_W-1:0]    tag_q, tag_d, rsp_tag_q, rsp_tag_d;
  logic                any_valid, grant;
  // grant the favoured requester if it is valid, otherwise the other one
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    grant      = (rr_q ? req1_valid : req0_valid) ? rr_q : ~rr_q;
    req0_ready = (state_q == IDLE) && any_valid && !grant;
    req1_ready = (state_q == IDLE) && any_valid && grant;
  end
  // next state: capture the granted op, run the ALU for one cycle, then hold the result until taken
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    src_d       = src_q;
    tag_d       = tag_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_ctrl_d  = alu_ctrl_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_tag_d   = rsp_tag_q;
    rsp_src_d   = rsp_src_q;
    if (state_q == IDLE && any_valid) begin
      alu_a_d    = grant ? req1_a : req0_a;
      alu_b_d    = grant ? req1_b : req0_b;
      alu_ctrl_d = grant ? req1_ctrl : req0_ctrl;
      tag_d      = grant ? req1_tag : req0_tag;
      src_d      = grant;
      rr_d       = ~grant;
      state_d    = EXEC;
    end else if (state_q == EXEC) begin
      rsp_data_d  = alu_result;
      rsp_tag_d   = tag_q;
      rsp_src_d   = src_q;
      rsp_valid_d = 1'b1;
      state_d     = RESP;
    end else if (state_q == RESP && rsp_ready) begin
      rsp_valid_d = 1'b0;
      state_d     = IDLE;
    end
    busy_d = state_d != IDLE;
  end
  // all state and registered outputs; reset discards any op in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= RR_INIT;
      src_q       <= 1'b0;
      tag_q       <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_ctrl_q  <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_tag_q   <= '0;
      rsp_src_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      src_q       <= src_d;
      tag_q       <= tag_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_ctrl_q  <= alu_ctrl_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_tag_q   <= rsp_tag_d;
      rsp_src_q   <= rsp_src_d;
      busy_q      <= busy_d;
    end
  end
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_control = alu_ctrl_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_tag     = rsp_tag_q;
  assign rsp_src     = rsp_src_q;
  assign busy        = busy_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb_alu_share_arbiter: directed and randomized checks of the shared-ALU arbiter against a queue model
module tb_alu_share_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  req0_ctrl, req0_tag, req1_ctrl, req1_tag;
  logic [31:0] alu_a, alu_b, alu_result, rsp_data;
  logic [3:0]  alu_control, rsp_tag;
  logic        rsp_valid, rsp_ready, rsp_src, busy;
  typedef struct {
    logic [31:0] d;
    logic [3:0]  t;
    logic        s;
    int          due;
  } rsp_t;
  rsp_t        q[$];
  logic        pop_src[$];
  logic [31:0] pop_data;
  logic        fav;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_c;
  int          cyc = 0;
  int          n_pass = 0;
  int          n_tot = 0;
  always #5 clk = ~clk;
  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] c);
    case (c)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a & b;
      4'd3:    return a | b;
      4'd5:    return a ^ b;
      4'd14:   return b;
      default: return 32'd0;
    endcase
  endfunction
  assign alu_result = alu_fn(alu_a, alu_b, alu_control);
  alu_share_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_ctrl(req0_ctrl), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_ctrl(req1_ctrl), .req1_tag(req1_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_src(rsp_src), .busy(busy)
  );
  task automatic chk(input string nm, input logic [31:0] o, input logic [31:0] e);
    n_tot++;
    assert (o === e) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", nm, o, e);
  endtask
  task automatic model_reset();
    q.delete();
    fav = 1'b0;
    m_a = '0;
    m_b = '0;
    m_c = '0;
  endtask
  task automatic drv(input bit n, input bit v, input logic [31:0] a, input logic [31:0] b,
                     input logic [3:0] c, input logic [3:0] t);
    if (n) begin
      req1_valid = v; req1_a = a; req1_b = b; req1_ctrl = c; req1_tag = t;
    end else begin
      req0_valid = v; req0_a = a; req0_b = b; req0_ctrl = c; req0_tag = t;
    end
  endtask
  task automatic step();
    logic e0, e1, ev;
    rsp_t r;
    @(negedge clk);
    e0 = q.size() == 0 && req0_valid && (!fav || !req1_valid);
    e1 = q.size() == 0 && req1_valid && (fav || !req0_valid);
    ev = q.size() > 0 && cyc >= q[0].due;
    chk("req0_ready", 32'(req0_ready), 32'(e0));
    chk("req1_ready", 32'(req1_ready), 32'(e1));
    chk("busy", 32'(busy), 32'(q.size() > 0));
    chk("rsp_valid", 32'(rsp_valid), 32'(ev));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    chk("alu_control", 32'(alu_control), 32'(m_c));
    if (ev) begin
      chk("rsp_data", rsp_data, q[0].d);
      chk("rsp_tag", 32'(rsp_tag), 32'(q[0].t));
      chk("rsp_src", 32'(rsp_src), 32'(q[0].s));
      if (rsp_ready) begin
        pop_src.push_back(rsp_src);
        pop_data = rsp_data;
        void'(q.pop_front());
      end
    end
    if (e0 || e1) begin
      m_a = e1 ? req1_a : req0_a;
      m_b = e1 ? req1_b : req0_b;
      m_c = e1 ? req1_ctrl : req0_ctrl;
      r.d = alu_fn(m_a, m_b, m_c);
      r.t = e1 ? req1_tag : req0_tag;
      r.s = e1;
      r.due = cyc + 2;
      q.push_back(r);
      fav = ~e1;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask
  task automatic run_until_pops(input int n);
    int tgt;
    tgt = pop_src.size() + n;
    for (int i = 0; i < 100 && pop_src.size() < tgt; i++) step();
    chk("pop_count", 32'(pop_src.size()), 32'(tgt));
  endtask
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_alu_control", 32'(alu_control), 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_src", 32'(rsp_src), 32'd0);
    model_reset();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask
  initial begin
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0);
    rsp_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    do_reset();
    // T1: single op from requester 0
    rsp_ready = 1'b1;
    drv(0, 1, 32'd5, 32'd3, 4'b0001, 4'd2);
    step();
    req0_valid = 1'b0;
    run_until_pops(1);
    chk("t1_data", pop_data, 32'd2);
    // T2: both valid after reset, requester 0 goes first
    do_reset();
    pop_src.delete();
    drv(0, 1, 32'd1, 32'd2, 4'b0000, 4'd1);
    drv(1, 1, 32'hF0, 32'h0F, 4'b0101, 4'd3);
    step();
    req0_valid = 1'b0;
    run_until_pops(2);
    req1_valid = 1'b0;
    chk("t2_first_src", 32'(pop_src[0]), 32'd0);
    chk("t2_second_src", 32'(pop_src[1]), 32'd1);
    chk("t2_second_data", pop_data, 32'hFF);
    // T3: response backpressure holds everything stable
    rsp_ready = 1'b0;
    drv(0, 1, 32'd100, 32'd1, 4'b0001, 4'd7);
    step();
    drv(0, 0, 0, 0, 0, 0);
    drv(1, 1, 32'd9, 32'd9, 4'b0000, 4'd9);
    repeat (7) step();
    chk("t3_busy", 32'(busy), 32'd1);
    chk("t3_req1_ready", 32'(req1_ready), 32'd0);
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    run_until_pops(1);
    chk("t3_data", pop_data, 32'd99);
    // T4: continuous contention alternates grants
    do_reset();
    pop_src.delete();
    drv(0, 1, 32'd10, 32'd4, 4'b0001, 4'd4);
    drv(1, 1, 32'd10, 32'd4, 4'b0000, 4'd5);
    run_until_pops(4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    for (int i = 0; i < 4; i++) chk("t4_src_seq", 32'(pop_src[i]), 32'(i % 2));
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    step();
    chk("t4_ptr_back_to_0", 32'(alu_control), 32'd1);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    run_until_pops(1);
    // T6: pass-through and undefined opcodes
    drv(0, 1, 32'hDEAD, 32'h12345000, 4'b1110, 4'd6);
    step();
    req0_valid = 1'b0;
    run_until_pops(1);
    chk("t6_pass_b", pop_data, 32'h12345000);
    drv(1, 1, 32'hDEAD, 32'h12345000, 4'b1111, 4'd6);
    step();
    req1_valid = 1'b0;
    run_until_pops(1);
    chk("t6_op_f", pop_data, 32'd0);
    // T5: reset during EXEC and during RESP discards the op
    drv(0, 1, 32'd7, 32'd7, 4'b0000, 4'd1);
    step();
    req0_valid = 1'b0;
    do_reset();
    repeat (4) step();
    rsp_ready = 1'b0;
    drv(1, 1, 32'd7, 32'd8, 4'b0010, 4'd2);
    step();
    req1_valid = 1'b0;
    repeat (2) step();
    do_reset();
    repeat (4) step();
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      drv(0, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      drv(1, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    repeat (6) step();
    chk("drained", 32'(busy), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
